// File: rtl/seg_scan_ndigit.sv
// seg_scan_ndigit: multiplexed N-digit 7-segment driver with a one-bit-per-clock double-dabble converter.
// Define SEG_LZB_EN to enable leading-zero blanking; otherwise every digit is shown.
`timescale 1ns/1ps
module seg_scan_ndigit #(
  parameter int BIN_W    = 16,
  parameter int DIGITS   = 5,
  parameter int SCAN_DIV = 500000,
  parameter int CNT_W    = 20
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [BIN_W-1:0]  BIN_IN,
  input  logic [DIGITS-1:0] DP_IN,
  output logic              BUSY,
  output logic              OVF,
  output logic [7:0]        SEG,
  output logic [DIGITS-1:0] AN
);

  localparam int SCR_CALC = 4 * ((BIN_W * 302 + 999) / 1000) + 4;
  localparam int DISP_W   = 4 * DIGITS;
  localparam int BCD_W    = (SCR_CALC > DISP_W) ? SCR_CALC : DISP_W;
  localparam int BC_W     = $clog2(BIN_W + 1);
  localparam int IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t             state, state_nx;
  logic [BIN_W-1:0]   shreg, last;
  logic [BCD_W-1:0]   bcd, bcd_adj;
  logic [BC_W-1:0]    bit_cnt;
  logic [DISP_W-1:0]  disp;
  logic               valid, scr_hi;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   idx, idx_nx;
  logic               tick, blank;
  logic [3:0]         nib;
  logic [6:0]         pat;
  logic [DIGITS-1:0]  an_nx;

  // {a,b,c,d,e,f,g}, active-low; codes 10..15 are blank.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b0000001;
      4'd1:    seg7 = 7'b1001111;
      4'd2:    seg7 = 7'b0010010;
      4'd3:    seg7 = 7'b0000110;
      4'd4:    seg7 = 7'b1001100;
      4'd5:    seg7 = 7'b0100100;
      4'd6:    seg7 = 7'b0100000;
      4'd7:    seg7 = 7'b0001111;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0000100;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
    state_nx = state;
    BUSY     = 1'b0;
    unique case (state)
      S_IDLE:  if (!valid || BIN_IN != last) state_nx = S_SHIFT;
      S_SHIFT: begin
        BUSY = 1'b1;
        if (bit_cnt == BC_W'(BIN_W - 1)) state_nx = S_DONE;
      end
      S_DONE: begin
        BUSY     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Add-3 correction on every nibble; scr_hi flags BCD digits beyond the display.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < BCD_W / 4; i++)
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    scr_hi = 1'b0;
    for (int i = DISP_W; i < BCD_W; i++) scr_hi = scr_hi | bcd[i];
  end

  always_ff @(posedge CLK) begin
    // NOTE: registered state is updated with <= so every flop samples pre-edge values regardless of statement order.
    if (RST) begin
      shreg   <= '0;
      last    <= '0;
      bcd     <= '0;
      bit_cnt <= '0;
      disp    <= '0;
      valid   <= 1'b0;
      OVF     <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: if (state_nx == S_SHIFT) begin
          shreg   <= BIN_IN;
          last    <= BIN_IN;
          bcd     <= '0;
          bit_cnt <= '0;
        end
        S_SHIFT: begin
          bcd     <= {bcd_adj[BCD_W-2:0], shreg[BIN_W-1]};
          shreg   <= shreg << 1;
          bit_cnt <= bit_cnt + 1'b1;
        end
        S_DONE: begin
          disp  <= bcd[DISP_W-1:0];
          OVF   <= scr_hi;
          valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Scan: everything shown for a slot is computed for the digit about to be selected.
  always_comb begin
    tick   = (cnt == CNT_W'(SCAN_DIV - 1));
    idx_nx = (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
    nib    = disp[4*idx_nx +: 4];
    blank  = 1'b0;
`ifdef SEG_LZB_EN
    blank  = (idx_nx != '0) && ((disp >> (4 * idx_nx)) == '0);
`endif
    if (OVF)        pat = 7'b1111110;
    else if (blank) pat = 7'b1111111;
    else            pat = seg7(nib);
    an_nx = ~(DIGITS'(1) << idx_nx);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt <= '0;
      idx <= '0;
      SEG <= 8'hFF;
      AN  <= '1;
    end else if (tick) begin
      cnt <= '0;
      idx <= idx_nx;
      SEG <= {pat, ~DP_IN[idx_nx]};
      AN  <= an_nx;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_seg_scan_ndigit.sv
// Bench for seg_scan_ndigit: integer-level display model checked every cycle, directed literals, random stimulus.
// Honours SEG_LZB_EN the same way as the design.
`timescale 1ns/1ps
module tb_seg_scan_ndigit;

  localparam int BIN_W    = 16;
  localparam int DIGITS   = 5;
  localparam int SCAN_DIV = 4;
  localparam int CNT_W    = 2;
  localparam longint LIMIT = 100000;
`ifdef SEG_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] BIN_IN = '0;
  logic [4:0]  DP_IN = '0;
  logic        BUSY, OVF;
  logic [7:0]  SEG;
  logic [4:0]  AN;

  logic [15:0] BIN_IN4 = '0;
  logic [3:0]  DP_IN4 = '0;
  logic        BUSY4, OVF4;
  logic [7:0]  SEG4;
  logic [3:0]  AN4;

  seg_scan_ndigit #(.BIN_W(BIN_W), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .CNT_W(CNT_W)) u_dut (
    .CLK(CLK), .RST(RST), .BIN_IN(BIN_IN), .DP_IN(DP_IN),
    .BUSY(BUSY), .OVF(OVF), .SEG(SEG), .AN(AN)
  );

  seg_scan_ndigit #(.BIN_W(BIN_W), .DIGITS(4), .SCAN_DIV(SCAN_DIV), .CNT_W(CNT_W)) u_dut4 (
    .CLK(CLK), .RST(RST), .BIN_IN(BIN_IN4), .DP_IN(DP_IN4),
    .BUSY(BUSY4), .OVF(OVF4), .SEG(SEG4), .AN(AN4)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Lit segments a..g as active-high, inverted for the pins.
  function automatic logic [6:0] glyph(input int d);
    logic [6:0] lit;
    case (d)
      0: lit = 7'b1111110;
      1: lit = 7'b0110000;
      2: lit = 7'b1101101;
      3: lit = 7'b1111001;
      4: lit = 7'b0110011;
      5: lit = 7'b1011011;
      6: lit = 7'b1011111;
      7: lit = 7'b1110000;
      8: lit = 7'b1111111;
      default: lit = 7'b1111011;
    endcase
    return ~lit;
  endfunction

  function automatic logic [7:0] exp_seg(input longint val, input bit ovf, input int idx, input logic dp);
    longint pw = 1;
    logic [6:0] p;
    for (int k = 0; k < idx; k++) pw = pw * 10;
    if (ovf)                            p = 7'b1111110;
    else if (LZB && idx != 0 && val < pw) p = 7'b1111111;
    else                                p = glyph(int'((val / pw) % 10));
    return {p, ~dp};
  endfunction

  // Model: what value is on display, when a conversion is pending, and which digit is selected.
  bit          m_known = 1'b0;
  bit          m_valid = 1'b0;
  bit          m_ovf = 1'b0;
  longint      m_val = 0;
  int          m_left = 0;
  logic [15:0] m_last = '0;
  logic [15:0] m_pend = '0;
  int          m_div = 0;
  int          m_idx = 0;
  logic [7:0]  m_seg = 8'hFF;
  logic [4:0]  m_an = '1;

  always @(posedge CLK) begin
    if (RST) begin
      m_known <= 1'b1;
      m_valid <= 1'b0;
      m_ovf   <= 1'b0;
      m_val   <= 0;
      m_left  <= 0;
      m_div   <= 0;
      m_idx   <= 0;
      m_seg   <= 8'hFF;
      m_an    <= '1;
    end else begin
      if (m_left == 0) begin
        if (!m_valid || BIN_IN !== m_last) begin
          m_last <= BIN_IN;
          m_pend <= BIN_IN;
          m_left <= BIN_W + 1;
        end
      end else begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_val   <= longint'(m_pend);
          m_ovf   <= (longint'(m_pend) >= LIMIT);
          m_valid <= 1'b1;
        end
      end
      if (m_div == SCAN_DIV - 1) begin
        m_div <= 0;
        m_idx <= (m_idx + 1) % DIGITS;
        m_an  <= ~(5'(1) << ((m_idx + 1) % DIGITS));
        m_seg <= exp_seg(m_val, m_ovf, (m_idx + 1) % DIGITS, DP_IN[(m_idx + 1) % DIGITS]);
      end else begin
        m_div <= m_div + 1;
      end
    end
  end

  always @(negedge CLK) begin
    if (m_known) begin
      check("busy", BUSY, (m_left != 0));
      check("ovf", OVF, m_ovf);
      check("seg", SEG, m_seg);
      check("an", AN, m_an);
    end
  end

  task automatic wait_an(input logic [4:0] tgt);
    for (int i = 0; i < 4 * DIGITS * SCAN_DIV + 4; i++) begin
      @(negedge CLK);
      if (AN === tgt) break;
    end
    check("wait_an", AN, tgt);
  endtask

  task automatic wait_an4(input logic [3:0] tgt);
    for (int i = 0; i < 4 * 4 * SCAN_DIV + 4; i++) begin
      @(negedge CLK);
      if (AN4 === tgt) break;
    end
    check("wait_an4", AN4, tgt);
  endtask

  function automatic logic [15:0] pick_val();
    case ($urandom_range(0, 5))
      0: return 16'd0;
      1: return 16'hFFFF;
      2: return 16'(9999 + $urandom_range(0, 1));
      3: return 16'(99 + $urandom_range(0, 1));
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    int nbusy, rises;
    logic [4:0] first_an;
    logic prev;

    // Reset state
    repeat (3) @(negedge CLK);
    check("rst_seg", SEG, 8'hFF);
    check("rst_an", AN, 5'b11111);
    check("rst_busy", BUSY, 1'b0);
    check("rst_ovf", OVF, 1'b0);

    // 12345: busy length, first lit anode, digits
    BIN_IN = 16'd12345;
    RST = 1'b0;
    nbusy = 0;
    first_an = '1;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (BUSY) nbusy++;
      if (first_an === 5'b11111 && AN !== 5'b11111) first_an = AN;
    end
    check("busy_len", nbusy, 17);
    check("first_an", first_an, 5'b11101);
    wait_an(5'b11110);
    check("d0_12345", SEG, 8'h49);
    wait_an(5'b01111);
    check("d4_12345", SEG, 8'h9F);
    check("ovf_12345", OVF, 1'b0);

    // Zero after reset converts unconditionally
    RST = 1'b1;
    BIN_IN = 16'd0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    repeat (24) @(negedge CLK);
    for (int d = 0; d < DIGITS; d++) begin
      wait_an(~(5'(1) << d));
      check("zero_digit", SEG, (LZB && d != 0) ? 8'hFF : 8'h03);
    end

    // Decimal point on digit 2 with 314
    DP_IN = 5'b00100;
    BIN_IN = 16'd314;
    repeat (24) @(negedge CLK);
    wait_an(5'b11011);
    check("dp_d2", SEG, 8'h0C);
    wait_an(5'b11110);
    check("dp_d0", SEG, 8'h99);
    wait_an(5'b10111);
    check("dp_d3", SEG, LZB ? 8'hFF : 8'h03);

    // 100 -> 200 -> 300 while shifting: exactly two conversions
    DP_IN = 5'b00000;
    prev = BUSY;
    BIN_IN = 16'd100;
    rises = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      if (i == 2) BIN_IN = 16'd200;
      if (i == 5) BIN_IN = 16'd300;
      if (BUSY && !prev) rises++;
      prev = BUSY;
    end
    check("conv_count", rises, 2);
    wait_an(5'b11011);
    check("d2_300", SEG, 8'h0D);
    wait_an(5'b11110);
    check("d0_300", SEG, 8'h03);

    // Reset during the 8th shift cycle
    BIN_IN = 16'd5555;
    repeat (8) @(negedge CLK);
    check("busy_mid", BUSY, 1'b1);
    RST = 1'b1;
    @(negedge CLK);
    check("abort_seg", SEG, 8'hFF);
    check("abort_an", AN, 5'b11111);
    check("abort_busy", BUSY, 1'b0);
    RST = 1'b0;
    repeat (24) @(negedge CLK);
    wait_an(5'b11110);
    check("d0_5555", SEG, 8'h49);

    // Four-digit instance: overflow boundary
    BIN_IN4 = 16'd65535;
    repeat (25) @(negedge CLK);
    check("ovf4_65535", OVF4, 1'b1);
    wait_an4(4'b1110);
    check("seg4_ovf_d0", SEG4, 8'hFD);
    wait_an4(4'b0111);
    check("seg4_ovf_d3", SEG4, 8'hFD);
    BIN_IN4 = 16'd9999;
    repeat (25) @(negedge CLK);
    check("ovf4_9999", OVF4, 1'b0);
    wait_an4(4'b1110);
    check("seg4_9999_d0", SEG4, 8'h09);
    wait_an4(4'b0111);
    check("seg4_9999_d3", SEG4, 8'h09);
    BIN_IN4 = 16'd10000;
    repeat (25) @(negedge CLK);
    check("ovf4_10000", OVF4, 1'b1);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge CLK);
      if (RST) RST = 1'b0;
      else if ($urandom_range(0, 299) == 0) RST = 1'b1;
      if ($urandom_range(0, 24) == 0) BIN_IN = pick_val();
      if ($urandom_range(0, 39) == 0) DP_IN = 5'($urandom);
    end
    RST = 1'b0;
    repeat (40) @(negedge CLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
